inst_cache: RTL and testbench
=============================

Name: inst_cache

Overview:
- Direct-mapped, read-only instruction cache between the fetch-stage PC and instruction memory.
- Takes the fetch PC and returns the instruction word plus a hit flag. The fetch stage advances its PC only on hit, or always when the cache is disabled.
- On a miss, it refills a whole line from memory through a req/ready handshake.
- In bypass mode (cache_en=0) it forwards memory data combinationally.

Parameters:
- LINES, 16, number of cache lines (power of 2, ≥2)
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2, ≥2)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous reset, active-high
- pc  input  32  byte address of the instruction being fetched
- cache_en  input  1  1 = cached mode, 0 = bypass
- flush  input  1  invalidate all lines (one-cycle pulse)
- inst  output  32  instruction word for pc
- hit  output  1  inst is valid from cache this cycle
- mem_req  output  1  memory read request
- mem_addr  output  32  memory word address (byte address, bits[1:0]=0)
- mem_rdata  input  32  memory read data, valid when mem_ready=1
- mem_ready  input  1  memory accepts request and returns mem_rdata this cycle

Behaviour:
- Address split (OB=log2 WORDS_PER_LINE, IB=log2 LINES):
  - bits[1:0] ignored
  - word offset = pc[OB+1:2]
  - index = pc[OB+IB+1:OB+2]
  - tag = the remaining upper bits
- Storage: data array LINES×WORDS_PER_LINE×32, a tag per line, a valid bit per line.
- Reset: all valid bits 0, state IDLE, refill counter 0, mem_req=0, hit=0, inst=0.
- Bypass (cache_en=0), purely combinational:
  - mem_req=1, mem_addr={pc[31:2],2'b00}, inst=mem_rdata, hit=0.
  - FSM must be in IDLE. If cache_en drops during REFILL, the refill aborts to IDLE next edge and the line stays invalid.
- Cached mode, lookup is combinational:
  - hit=1 when state==IDLE, valid[index], and tag match.
  - inst = selected word; inst=0 when hit=0.
- FSM states:
  - IDLE: on a miss with cache_en=1 and flush=0, latch tag and index, clear the counter, go to REFILL next edge.
  - REFILL:
    - Outputs: mem_req=1, mem_addr={latched tag, latched index, counter, 2'b00}.
    - Each cycle with mem_ready=1, write mem_rdata into word[counter] and increment the counter.
    - When mem_ready=1 and counter==WORDS_PER_LINE-1: write the tag, set valid, go to IDLE.
    - hit stays 0 throughout REFILL.
  - Miss penalty is WORDS_PER_LINE accepted beats plus 1 cycle. Earliest hit is the cycle after the final beat.
- pc changing during REFILL: the line for the latched address still completes. Lookup in IDLE then uses the current pc and may miss again.
- flush=1:
  - Clears all valid bits at the edge.
  - In REFILL: aborts to IDLE and the line is not validated.
  - Forces hit=0 in that same cycle.
  - Takes priority over refill completion in the same cycle.
- rst mid-refill: same outcome as reset; any in-flight memory beat is dropped.
- Memory handshake:
  - mem_addr is stable while mem_req=1 and mem_ready=0.
  - mem_req deasserts in IDLE in cached mode.

Optional Feature:
- Macro: INST_CACHE_STATS_EN.
- When defined, adds outputs hit_count[31:0] and miss_count[31:0]. Both are reset to 0.
  - hit_count increments on each cycle with cache_en=1, hit=1, flush=0.
  - miss_count increments on each IDLE→REFILL transition.
  - Both counters wrap modulo 2^32.
- When not defined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Cold miss: reset, cache_en=1, pc=0x40, mem_ready always 1, mem_rdata=addr+0x1000.
  - mem_addr sequence 0x40,0x44,0x48,0x4C.
  - hit=1 on cycle 6 after reset release, with inst=0x1040.
  - Then pc=0x48 hits immediately with inst=0x1048.
- Conflict eviction: fill line for pc=0x40, then pc=0x40+16·LINES·4=0x440.
  - Miss and refill.
  - Returning to 0x40 misses again (miss_count=3 with INST_CACHE_STATS_EN).
- Slow memory: mem_ready asserted every 3rd cycle.
  - mem_addr is held between beats.
  - Refill of 4 words takes ~12 cycles, then hit=1.
- Flush mid-refill: flush pulse after the 2nd beat.
  - Next cycle state is IDLE, mem_req drops, hit=0.
  - Re-fetch of the same pc starts a new refill at word 0.
- Bypass: cache_en=0, pc=0x100, mem_rdata=0xDEADBEEF.
  - mem_addr=0x100, inst=0xDEADBEEF same cycle, hit=0, no valid bits set.
- Reset mid-refill: rst asserted during REFILL.
  - All outputs return to reset values.
  - Prior-resident line misses after reset.

Source files
------------

// File: rtl/inst_cache.sv
// Purpose : direct-mapped read-only instruction cache between fetch PC and instruction memory.
// Latency : lookup is combinational; a miss costs WORDS_PER_LINE accepted beats plus one cycle.
// Backpr. : refill beats advance only when mem_ready=1; mem_addr holds while mem_req=1 and mem_ready=0.
//
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   pc, cache_en, flush - fetch byte address, 1=cached/0=bypass, invalidate-all pulse
//   inst, hit           - instruction word for pc and "served from cache this cycle"
//   mem_req, mem_addr   - memory read request and word-aligned byte address
//   mem_rdata, mem_ready- memory read data, accepted/returned when mem_ready=1
// Optional: define INST_CACHE_STATS_EN to add hit_count / miss_count outputs.

module inst_cache #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        cache_en,
    input  logic        flush,
    output logic [31:0] inst,
    output logic        hit,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
`ifdef INST_CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int OB = $clog2(WORDS_PER_LINE);
    localparam int IB = $clog2(LINES);
    localparam int TW = 30 - OB - IB;
    localparam logic [OB-1:0] LAST_WORD = OB'(WORDS_PER_LINE - 1);

    typedef enum logic {IDLE, REFILL} state_t;

    state_t state, state_nxt;

    logic [31:0]   data_arr [LINES][WORDS_PER_LINE];
    logic [TW-1:0] tag_arr  [LINES];
    logic [LINES-1:0] valid;

    logic [OB-1:0] cnt;
    logic [TW-1:0] lat_tag;
    logic [IB-1:0] lat_idx;

    // address split of the current fetch PC
    logic [OB-1:0] pc_off;
    logic [IB-1:0] pc_idx;
    logic [TW-1:0] pc_tag;
    logic          pc_unused;

    assign pc_off    = pc[OB+1:2];
    assign pc_idx    = pc[OB+IB+1:OB+2];
    assign pc_tag    = pc[31:OB+IB+2];
    assign pc_unused = ^pc[1:0];

    logic lookup_hit;
    assign lookup_hit = (state == IDLE) && valid[pc_idx] && (tag_arr[pc_idx] == pc_tag);

    logic start_refill;
    logic beat_wr;
    logic line_done;

    // next-state and datapath strobes
    always_comb begin
        state_nxt    = state;
        start_refill = 1'b0;
        beat_wr      = 1'b0;
        line_done    = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (cache_en && !flush && !lookup_hit) begin
                        state_nxt    = REFILL;
                        start_refill = 1'b1;
                    end
                end
                REFILL: begin
                    // flush and bypass both abandon the line; flush wins over completion
                    if (flush || !cache_en) begin
                        state_nxt = IDLE;
                    end else if (mem_ready) begin
                        beat_wr = 1'b1;
                        if (cnt == LAST_WORD) begin
                            line_done = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= '0;
            cnt     <= '0;
            lat_tag <= '0;
            lat_idx <= '0;
        end else begin
            if (start_refill) begin
                lat_tag <= pc_tag;
                lat_idx <= pc_idx;
                cnt     <= '0;
                // the victim line is overwritten word by word, so it must stop hitting now
                valid[pc_idx] <= 1'b0;
            end
            if (beat_wr) begin
                cnt <= cnt + 1'b1;
            end
            if (line_done) begin
                valid[lat_idx] <= 1'b1;
            end
            if (flush) begin
                valid <= '0;
            end
        end
    end

    // storage arrays carry no reset; valid bits gate every read
    always_ff @(posedge clk) begin
        if (beat_wr) begin
            data_arr[lat_idx][cnt] <= mem_rdata;
        end
        if (line_done) begin
            tag_arr[lat_idx] <= lat_tag;
        end
    end

    always_comb begin
        hit      = 1'b0;
        inst     = '0;
        mem_req  = 1'b0;
        mem_addr = {pc[31:2], 2'b00};
        if (!cache_en) begin
            mem_req = 1'b1;
            inst    = mem_rdata;
        end else if (state == REFILL) begin
            mem_req  = 1'b1;
            mem_addr = {lat_tag, lat_idx, cnt, 2'b00};
        end else if (lookup_hit && !flush) begin
            hit  = 1'b1;
            inst = data_arr[pc_idx][pc_off];
        end
    end

`ifdef INST_CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (cache_en && hit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (start_refill) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Purpose : self-checking bench for inst_cache (directed literal checks plus randomized run).
// Latency : inputs change 1 time unit after each rising edge; outputs sampled before the falling edge.
// Backpr. : memory model answers mem_rdata = mem_addr + 0x1000 with a randomized mem_ready.

module tb_inst_cache;

    localparam int LINES = 16;
    localparam int WPL   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        cache_en;
    logic        flush;
    logic [31:0] inst;
    logic        hit;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        ovr_en;
    logic [31:0] ovr_val;
`ifdef INST_CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // memory content is a fixed function of the address, so any cached word must equal it
    assign mem_rdata = ovr_en ? ovr_val : mem_addr + 32'h1000;

    inst_cache #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .cache_en  (cache_en),
        .flush     (flush),
        .inst      (inst),
        .hit       (hit),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
`ifdef INST_CACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // Tracks which memory line (pc / line bytes) each slot holds, and an
    // outstanding refill as (line number, beats received).
    bit          m_valid [LINES];
    int unsigned m_line  [LINES];
    bit          m_busy  = 1'b0;
    int unsigned m_bline = 0;
    int unsigned m_beats = 0;
    int unsigned m_hits  = 0;
    int unsigned m_miss  = 0;

    always @(negedge clk) begin
        int unsigned ln;
        int unsigned ix;
        bit          raw_hit;
        bit          e_hit;
        logic [31:0] e_addr;
        logic [31:0] e_inst;

        ln      = pc / 32'(WPL * 4);
        ix      = ln % 32'(LINES);
        raw_hit = !m_busy && m_valid[ix] && (m_line[ix] == ln);
        e_addr  = pc & ~32'h3;

        if (!rst) begin
            if (!cache_en) begin
                e_inst = ovr_en ? ovr_val : e_addr + 32'h1000;
                chkb("m_byp_req", mem_req, 1'b1);
                chk ("m_byp_addr", mem_addr, e_addr);
                chk ("m_byp_inst", inst, e_inst);
                chkb("m_byp_hit", hit, 1'b0);
            end else begin
                e_hit = raw_hit && !flush;
                chkb("m_hit", hit, e_hit);
                chk ("m_inst", inst, e_hit ? e_addr + 32'h1000 : 32'h0);
                chkb("m_req", mem_req, m_busy);
                if (m_busy) begin
                    chk("m_addr", mem_addr, m_bline * 32'(WPL * 4) + m_beats * 32'd4);
                end
            end
`ifdef INST_CACHE_STATS_EN
            chk("m_hit_count", hit_count, m_hits);
            chk("m_miss_count", miss_count, m_miss);
`endif
        end

        if (rst) begin
            for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
            m_busy = 1'b0;
            m_hits = 0;
            m_miss = 0;
        end else begin
            if (cache_en && raw_hit && !flush) m_hits++;
            if (flush) begin
                for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
                m_busy = 1'b0;
            end else if (m_busy) begin
                if (!cache_en) begin
                    m_busy = 1'b0;
                end else if (mem_ready) begin
                    m_beats++;
                    if (m_beats == WPL) begin
                        m_valid[m_bline % LINES] = 1'b1;
                        m_line[m_bline % LINES]  = m_bline;
                        m_busy = 1'b0;
                    end
                end
            end else if (cache_en && !raw_hit) begin
                m_busy      = 1'b1;
                m_bline     = ln;
                m_beats     = 0;
                m_valid[ix] = 1'b0;
                m_miss++;
            end
        end
    end

    // ---------------- stimulus and literal checks ----------------
    initial begin
        rst = 1'b1; cache_en = 1'b1; flush = 1'b0; pc = 32'h40;
        mem_ready = 1'b1; ovr_en = 1'b0; ovr_val = 32'h0;
        repeat (3) tick();

        // cycle 1 after reset release
        rst = 1'b0;
        #1;
        chkb("rst_hit", hit, 1'b0);
        chkb("rst_req", mem_req, 1'b0);
        chk ("rst_inst", inst, 32'h0);

        // cold miss: beats on cycles 2..5, hit on cycle 6
        for (int b = 0; b < 4; b++) begin
            tick(); #1;
            chkb("cold_req", mem_req, 1'b1);
            chk ("cold_addr", mem_addr, 32'h40 + 32'(4 * b));
            chkb("cold_nohit", hit, 1'b0);
        end
        tick(); #1;
        chkb("cold_hit", hit, 1'b1);
        chk ("cold_inst", inst, 32'h1040);
        tick(); pc = 32'h48; #1;
        chkb("same_line_hit", hit, 1'b1);
        chk ("same_line_inst", inst, 32'h1048);

        // conflict eviction through the same index
        tick(); pc = 32'h440; #1;
        chkb("conf_miss", hit, 1'b0);
        repeat (5) tick();
        #1;
        chkb("conf_hit", hit, 1'b1);
        chk ("conf_inst", inst, 32'h1440);
        tick(); pc = 32'h40; #1;
        chkb("evicted_miss", hit, 1'b0);
        repeat (5) tick();
        #1;
        chkb("refetch_hit", hit, 1'b1);
        chk ("refetch_inst", inst, 32'h1040);
`ifdef INST_CACHE_STATS_EN
        chk("miss_count3", miss_count, 32'd3);
`endif

        // slow memory: ready every third cycle
        tick(); pc = 32'h80; mem_ready = 1'b0; #1;
        chkb("slow_miss", hit, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            tick();
            mem_ready = (k % 3 == 0);
            #1;
            chkb("slow_hit", hit, k == 13);
            if (k < 13) chk("slow_addr", mem_addr, 32'h80 + 32'(4 * ((k - 1) / 3)));
        end
        mem_ready = 1'b1;

        // flush after the second beat
        tick(); pc = 32'hC0; #1;
        tick(); tick();
        tick(); flush = 1'b1; #1;
        chkb("flush_hit", hit, 1'b0);
        tick(); flush = 1'b0; #1;
        chkb("flush_req_drop", mem_req, 1'b0);
        chkb("flush_idle_hit", hit, 1'b0);
        tick(); #1;
        chkb("flush_rerefill_req", mem_req, 1'b1);
        chk ("flush_rerefill_addr", mem_addr, 32'hC0);
        repeat (4) tick();
        #1;
        chkb("flush_done_hit", hit, 1'b1);
        chk ("flush_done_inst", inst, 32'h10C0);
        tick(); pc = 32'h40; #1;
        chkb("flushed_line_miss", hit, 1'b0);
        repeat (5) tick();

        // bypass
        cache_en = 1'b0; pc = 32'h100; ovr_en = 1'b1; ovr_val = 32'hDEADBEEF; #1;
        chk ("byp_addr", mem_addr, 32'h100);
        chk ("byp_inst", inst, 32'hDEADBEEF);
        chkb("byp_hit", hit, 1'b0);
        chkb("byp_req", mem_req, 1'b1);
        tick(); cache_en = 1'b1; ovr_en = 1'b0; #1;
        chkb("byp_novalid", hit, 1'b0);
        chkb("byp_idle_req", mem_req, 1'b0);

        // reset in the middle of the 0x100 refill
        tick(); #1;
        chk("rstmid_addr", mem_addr, 32'h100);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; pc = 32'hC0; #1;
        chkb("rstmid_hit", hit, 1'b0);
        chkb("rstmid_req", mem_req, 1'b0);
        chk ("rstmid_inst", inst, 32'h0);
`ifdef INST_CACHE_STATS_EN
        chk("rstmid_hitcnt", hit_count, 32'd0);
        chk("rstmid_misscnt", miss_count, 32'd0);
`endif
        repeat (5) tick();

        // randomized run checked by the model
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst       = ($urandom_range(0, 299) == 0);
            flush     = ($urandom_range(0, 49) == 0);
            cache_en  = ($urandom_range(0, 9) != 0);
            mem_ready = ($urandom_range(0, 9) < 6);
            pc        = 32'($urandom_range(0, 39)) * 32'(WPL * 4) + 32'($urandom_range(0, 15));
        end
        tick();
        rst = 1'b0; flush = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
